// File: rtl/sfw_pkg.sv
// Shared types and default geometry for the SRAM frame writer.
package sfw_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    PACK,
    DONE
  } sfw_state_e;

  localparam int PIX_PER_WORD = 8;
  localparam int LANE_W       = $clog2(PIX_PER_WORD);

  localparam int DEF_ROW_STRIDE = 256;
  localparam int DEF_LINE_WORDS = 256;
  localparam int DEF_FRAME_ROWS = 200;

endpackage

// File: rtl/pix_word_packer.sv
// Collects pixels into 8-lane SRAM words. Lane 0 holds the first pixel of a
// group. A word is presented (combinationally) on the pixel that fills it or
// on an end-of-line pixel; lanes not yet filled read as zero because the lane
// register is cleared after every completed word. A restart discards any
// partial word and places the current pixel in lane 0.
module pix_word_packer
  import sfw_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int DATA_W = PIX_PER_WORD * PIX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixValid_i,
  input  logic              restart_i,
  input  logic [PIX_W-1:0]  pix_i,
  input  logic              eol_i,
  output logic [DATA_W-1:0] word_o,
  output logic              wordValid_o
);

  logic [DATA_W-1:0] lanes_q, lanes_d;
  logic [LANE_W-1:0] count_q, count_d;
  logic [DATA_W-1:0] baseLanes;
  logic [LANE_W-1:0] baseCount;

  // Merge the incoming pixel into its lane and decide whether the word is complete.
  always_comb begin
    baseLanes = restart_i ? '0 : lanes_q;
    baseCount = restart_i ? '0 : count_q;
    word_o    = baseLanes;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
      if (baseCount == LANE_W'(k)) begin
        word_o[k*PIX_W +: PIX_W] = pix_i;
      end
    end
    wordValid_o = pixValid_i && (eol_i || (baseCount == LANE_W'(PIX_PER_WORD - 1)));
    lanes_d     = lanes_q;
    count_d     = count_q;
    if (pixValid_i) begin
      if (wordValid_o) begin
        lanes_d = '0;
        count_d = '0;
      end else begin
        lanes_d = word_o;
        count_d = baseCount + LANE_W'(1);
      end
    end else if (restart_i) begin
      lanes_d = '0;
      count_d = '0;
    end
  end

  // Lane storage and fill count.
  always_ff @(posedge clk) begin
    if (reset) begin
      lanes_q <= '0;
      count_q <= '0;
    end else begin
      lanes_q <= lanes_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sram_frame_writer.sv
// Write side of the frame SRAM: packs an 8-bit pixel stream into 64-bit words
// and writes them row-major with a fixed row stride, matching the layout the
// 5-row column fetch reads back. Writes are registered (1 cycle after the
// completing pixel). Optional build macro SFW_CHECKSUM_EN adds frame_sum, the
// XOR of every word written in the current frame.
module sram_frame_writer
  import sfw_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 64,
  parameter int PIX_W      = 8,
  parameter int ROW_STRIDE = DEF_ROW_STRIDE,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int FRAME_ROWS = DEF_FRAME_ROWS,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              startEn,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_sof,
  input  logic              pix_eol,
  output logic              we,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              frame_done,
  output logic              ovf_err,
  output logic              sync_err
`ifdef SFW_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] frame_sum
`endif
);

  localparam int COL_W = $clog2(LINE_WORDS + 1);
  localparam int ROW_W = (FRAME_ROWS > 1) ? $clog2(FRAME_ROWS) : 1;

  sfw_state_e        state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              drop_q, drop_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              frameDone_q;
  logic              ovf_q;
  logic              sync_q;

  logic              ready;
  logic              accept;
  logic              take;
  logic              restart;
  logic [ROW_W-1:0]  rowEff;
  logic [COL_W-1:0]  colEff;
  logic              dropEff;
  logic              feed;
  logic [DATA_W-1:0] word;
  logic              wordValid;
  logic              overflow;
  logic              issue;
  logic              eolTake;
  logic              lastRow;
  logic [ADDR_W-1:0] wordAddr;

  // A sof pixel restarts the frame position, so the effective row/col/drop
  // seen by this pixel are zero in that case.
  assign ready   = (state_q == WAIT_SOF) || (state_q == PACK);
  assign accept  = pix_valid && ready;
  assign take    = accept && ((state_q == PACK) || pix_sof);
  assign restart = take && pix_sof;
  assign rowEff  = restart ? '0 : row_q;
  assign colEff  = restart ? '0 : col_q;
  assign dropEff = restart ? 1'b0 : drop_q;
  assign feed    = take && !dropEff;

  pix_word_packer #(
    .PIX_W (PIX_W),
    .DATA_W(DATA_W)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .pixValid_i (feed),
    .restart_i  (restart),
    .pix_i      (pix_data),
    .eol_i      (pix_eol),
    .word_o     (word),
    .wordValid_o(wordValid)
  );

  // Next-state, row/col advance, overflow detection and word address.
  always_comb begin
    overflow = wordValid && (colEff == COL_W'(LINE_WORDS));
    issue    = wordValid && !overflow;
    eolTake  = take && pix_eol;
    lastRow  = (rowEff == ROW_W'(FRAME_ROWS - 1));
    wordAddr = ADDR_W'(BASE_ADDR) + ADDR_W'(rowEff) * ADDR_W'(ROW_STRIDE) + ADDR_W'(colEff);
    state_d  = state_q;
    row_d    = rowEff;
    col_d    = colEff;
    drop_d   = dropEff;
    if (issue) begin
      col_d = colEff + COL_W'(1);
    end
    if (overflow && !pix_eol) begin
      drop_d = 1'b1;
    end
    if (eolTake) begin
      col_d  = '0;
      row_d  = rowEff + ROW_W'(1);
      drop_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (startEn) state_d = WAIT_SOF;
      end
      WAIT_SOF, PACK: begin
        if (eolTake && lastRow) state_d = DONE;
        else if (take) state_d = PACK;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters, registered SRAM write port and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      drop_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      frameDone_q <= 1'b0;
      ovf_q       <= 1'b0;
      sync_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      drop_q      <= drop_d;
      we_q        <= issue;
      frameDone_q <= (state_q == DONE);
      if (issue) begin
        addr_q <= wordAddr;
        data_q <= word;
      end
      if ((state_q == IDLE) && startEn) begin
        ovf_q  <= 1'b0;
        sync_q <= 1'b0;
      end else begin
        if (overflow) ovf_q <= 1'b1;
        if (restart && (state_q == PACK)) sync_q <= 1'b1;
      end
    end
  end

`ifdef SFW_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // Running XOR of the words written since the frame was armed.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else if ((state_q == IDLE) && startEn) begin
      sum_q <= '0;
    end else if (we_q) begin
      sum_q <= sum_q ^ data_q;
    end
  end

  assign frame_sum = sum_q;
`endif

  assign pix_ready  = ready;
  assign we         = we_q;
  assign write_addr = addr_q;
  assign data       = data_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = frameDone_q;
  assign ovf_err    = ovf_q;
  assign sync_err   = sync_q;

endmodule

// File: tb/tb_sram_frame_writer.sv
// Bench for sram_frame_writer: directed frames pinned with literal values,
// then random frames checked every cycle against a queue-based frame model.
module tb_sram_frame_writer;

  localparam int ADDR_W     = 11;
  localparam int DATA_W     = 64;
  localparam int PIX_W      = 8;
  localparam int ROW_STRIDE = 256;
  localparam int LINE_WORDS = 4;
  localparam int FRAME_ROWS = 3;
  localparam int BASE_ADDR  = 1792;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              startEn = 1'b0;
  logic              pix_valid = 1'b0;
  logic [PIX_W-1:0]  pix_data = '0;
  logic              pix_sof = 1'b0;
  logic              pix_eol = 1'b0;
  logic              pix_ready;
  logic              we;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              frame_done;
  logic              ovf_err;
  logic              sync_err;
`ifdef SFW_CHECKSUM_EN
  logic [DATA_W-1:0] frame_sum;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sram_frame_writer #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .PIX_W     (PIX_W),
    .ROW_STRIDE(ROW_STRIDE),
    .LINE_WORDS(LINE_WORDS),
    .FRAME_ROWS(FRAME_ROWS),
    .BASE_ADDR (BASE_ADDR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .startEn   (startEn),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .we        (we),
    .write_addr(write_addr),
    .data      (data),
    .busy      (busy),
    .frame_done(frame_done),
    .ovf_err   (ovf_err),
    .sync_err  (sync_err)
`ifdef SFW_CHECKSUM_EN
    ,
    .frame_sum (frame_sum)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Frame model: phase 0 idle, 1 waiting for sof, 2 in frame, 3 last word out.
  int               mPhase = 0;
  int               mRow = 0;
  int               mCol = 0;
  bit               mDrop = 0;
  logic [7:0]       pixq[$];
  logic             expWe = 0;
  logic             expDone = 0;
  logic             expOvf = 0;
  logic             expSync = 0;
  logic [ADDR_W-1:0] expAddr = '0;
  logic [63:0]      expData = '0;
  logic [63:0]      expSum = '0;
  bit               checkOn = 0;

  task automatic emitWord();
    if (mCol == LINE_WORDS) begin
      expOvf = 1'b1;
      if (!pix_eol) mDrop = 1;
    end else begin
      expWe   = 1'b1;
      expAddr = ADDR_W'((BASE_ADDR + mRow * ROW_STRIDE + mCol) % (1 << ADDR_W));
      expData = '0;
      foreach (pixq[k]) expData |= 64'(pixq[k]) << (8 * k);
      mCol++;
    end
    pixq.delete();
  endtask

  task automatic modelPixel();
    if (pix_sof) begin
      if (mPhase == 2) expSync = 1'b1;
      pixq.delete();
      mRow = 0;
      mCol = 0;
      mDrop = 0;
      mPhase = 2;
    end else if (mPhase == 1) begin
      return;
    end
    if (!mDrop) begin
      pixq.push_back(pix_data);
      if (pixq.size() == 8 || pix_eol) emitWord();
    end
    if (pix_eol) begin
      mRow++;
      mCol = 0;
      mDrop = 0;
      if (mRow == FRAME_ROWS) mPhase = 3;
    end
  endtask

  // Advance the model on each clock edge using the inputs held across it.
  always @(posedge clk) begin
    if (reset) begin
      mPhase = 0; mRow = 0; mCol = 0; mDrop = 0;
      pixq.delete();
      expWe = 0; expDone = 0; expOvf = 0; expSync = 0;
      expAddr = '0; expData = '0; expSum = '0;
      checkOn = 1;
    end else begin
      if (expWe) expSum ^= expData;
      expDone = (mPhase == 3);
      expWe = 1'b0;
      case (mPhase)
        0: if (startEn) begin
          mPhase = 1; expOvf = 0; expSync = 0; expSum = '0;
        end
        3: mPhase = 0;
        default: if (pix_valid) modelPixel();
      endcase
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (checkOn) begin
      checkOutput("we", we, expWe);
      if (expWe) begin
        checkOutput("write_addr", write_addr, expAddr);
        checkOutput("data", data, expData);
      end
      checkOutput("pix_ready", pix_ready, (mPhase == 1) || (mPhase == 2));
      checkOutput("busy", busy, mPhase != 0);
      checkOutput("frame_done", frame_done, expDone);
      checkOutput("ovf_err", ovf_err, expOvf);
      checkOutput("sync_err", sync_err, expSync);
`ifdef SFW_CHECKSUM_EN
      if (expDone) checkOutput("frame_sum", frame_sum, expSum);
`endif
    end
  end

  // Log of DUT writes for the literal checks.
  logic [ADDR_W-1:0] logAddr[$];
  logic [63:0]       logData[$];

  // Capture each SRAM write as it appears.
  always @(negedge clk) begin
    if (checkOn && we === 1'b1) begin
      logAddr.push_back(write_addr);
      logData.push_back(data);
    end
  end

  task automatic idleCycle();
    @(posedge clk); #1;
    pix_valid = 1'b0; startEn = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
  endtask

  task automatic pulseStart();
    @(posedge clk); #1;
    startEn = 1'b1; pix_valid = 1'b0;
    @(posedge clk); #1;
    startEn = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input bit sof, input bit eol, input bit noise);
    if (noise && $urandom_range(0, 3) == 0) idleCycle();
    @(posedge clk); #1;
    pix_valid = 1'b1; pix_data = d; pix_sof = sof; pix_eol = eol;
    startEn = noise && ($urandom_range(0, 31) == 0);
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    idleCycle();
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    checkOutput(name, frame_done, 1);
  endtask

  task automatic runRandomFrame();
    int rowsDone = 0;
    int rowPix = 0;
    int len;
    bit first = 1;
    bit sof, eol;
    pulseStart();
    repeat ($urandom_range(0, 3)) applyStimulus(8'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    len = $urandom_range(1, 45);
    while (rowsDone < FRAME_ROWS) begin
      sof = first;
      first = 0;
      if (!sof && $urandom_range(0, 79) == 0) begin
        sof = 1; rowsDone = 0; rowPix = 0; len = $urandom_range(1, 45);
      end
      eol = (rowPix == len - 1);
      applyStimulus(8'($urandom), sof, eol, 1'b1);
      rowPix++;
      if (eol) begin
        rowsDone++; rowPix = 0; len = $urandom_range(1, 45);
      end
    end
    waitDone("random_frame_done");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_we", we, 0);
    checkOutput("reset_addr", write_addr, 0);
    checkOutput("reset_data", data, 0);
    checkOutput("reset_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Frame 1: full words, partial word, overflow with drop.
    logAddr.delete(); logData.delete();
    pulseStart();
    for (int i = 0; i < 16; i++) applyStimulus(8'(i), i == 0, i == 15, 1'b0);
    applyStimulus(8'hAA, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hBB, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'hCC, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 44; i++) applyStimulus(8'(i), 1'b0, i == 43, 1'b0);
    waitDone("frame1_done");
    checkOutput("f1_count", logAddr.size(), 7);
    if (logAddr.size() == 7) begin
      checkOutput("f1_addr0", logAddr[0], 1792);
      checkOutput("f1_data0", logData[0], 64'h0706050403020100);
      checkOutput("f1_addr1", logAddr[1], 1793);
      checkOutput("f1_data1", logData[1], 64'h0F0E0D0C0B0A0908);
      checkOutput("f1_addr2", logAddr[2], 0);
      checkOutput("f1_data2", logData[2], 64'h0000000000CCBBAA);
      checkOutput("f1_addr6", logAddr[6], 259);
      checkOutput("f1_data6", logData[6], 64'h1F1E1D1C1B1A1918);
    end
    checkOutput("f1_ovf", ovf_err, 1);
    checkOutput("f1_sync", sync_err, 0);

    // Frame 2: resync in the middle of row 1.
    @(posedge clk);
    logAddr.delete(); logData.delete();
    pulseStart();
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'h10 + i), i == 0, i == 7, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(8'(8'h30 + i), i == 0, i == 7, 1'b0);
    applyStimulus(8'h40, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h41, 1'b0, 1'b1, 1'b0);
    waitDone("frame2_done");
    checkOutput("f2_count", logAddr.size(), 4);
    if (logAddr.size() == 4) begin
      checkOutput("f2_addr1", logAddr[1], 1792);
      checkOutput("f2_data1", logData[1], 64'h3736353433323130);
      checkOutput("f2_addr3", logAddr[3], 256);
      checkOutput("f2_data3", logData[3], 64'h41);
    end
    checkOutput("f2_sync", sync_err, 1);
    checkOutput("f2_ovf", ovf_err, 0);

    // Frame 3: reset in the middle of a row, then a fresh short frame.
    @(posedge clk);
    pulseStart();
    for (int i = 0; i < 5; i++) applyStimulus(8'(8'h55 + i), i == 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rst_we", we, 0);
    checkOutput("rst_addr", write_addr, 0);
    checkOutput("rst_data", data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ready", pix_ready, 0);
    checkOutput("rst_done", frame_done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    logAddr.delete(); logData.delete();
    pulseStart();
    applyStimulus(8'h01, 1'b1, 1'b1, 1'b0);
    applyStimulus(8'h02, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h03, 1'b0, 1'b1, 1'b0);
    waitDone("frame3_done");
    checkOutput("f3_count", logAddr.size(), 3);
    if (logAddr.size() == 3) begin
      checkOutput("f3_addr0", logAddr[0], 1792);
      checkOutput("f3_data0", logData[0], 64'h01);
    end

    // Random frames with gaps, junk before sof, stray startEn and resyncs.
    for (int f = 0; f < 25; f++) begin
      @(posedge clk);
      runRandomFrame();
    end
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
